dark_io_responder: RTL and testbench

//  Responder (slave) end of the device_bus handshake driven by the core-side memory map.

---
 rtl/darkio_pkg.sv | 18 +
 rtl/dark_io_timer.sv | 42 ++++
 rtl/dark_io_responder.sv | 113 +++++++++++
 tb/tb_dark_io_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/darkio_pkg.sv
// Shared types and register indices for the dark IO responder.
package darkio_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} io_state_t;

  localparam logic [2:0] IO_INFO    = 3'd0;
  localparam logic [2:0] IO_LEDGPIO = 3'd2;
  localparam logic [2:0] IO_RELOAD  = 3'd3;
  localparam logic [2:0] IO_COUNT   = 3'd4;

  typedef struct packed {
    logic        wr;
    logic [2:0]  idx;
    logic [3:0]  be;
    logic [31:0] data;
  } io_req_t;

endpackage

// File: rtl/dark_io_timer.sv
// Periodic down-counter with a single request/ack interrupt pair on bit 7.
module dark_io_timer #(
  parameter logic [31:0] RELOAD_INIT = 32'd99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload_we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        ack_we,
  input  logic [7:0]  ack_mask,
  output logic [31:0] reload,
  output logic [31:0] count,
  output logic [7:0]  irq
);

  logic [7:0] ireq, iack;

  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= RELOAD_INIT;
      count  <= '0;
      ireq   <= '0;
      iack   <= '0;
    end else begin
      if (reload_we)
        for (int b = 0; b < 4; b++)
          if (be[b]) reload[8*b +: 8] <= wdata[8*b +: 8];
      if (ack_we)
        for (int i = 0; i < 8; i++)
          if (ack_mask[i]) iack[i] <= ireq[i];
      // Set condition looks at pre-edge IREQ/IACK, so a same-cycle ack cannot mask or double a set.
      if (reload != 32'd0) begin
        count <= (count != 32'd0) ? count - 32'd1 : reload;
        if (count == 32'd0 && ireq == iack) ireq[7] <= ~iack[7];
      end
    end
  end

  assign irq = ireq ^ iack;

endmodule

// File: rtl/dark_io_responder.sv
// Device-bus responder: IO window decode, handshake FSM, LED/GPIO regs and the timer.
module dark_io_responder
  import darkio_pkg::*;
#(
  parameter logic [7:0]  BOARD_ID    = 8'h00,
  parameter int unsigned BOARD_CK    = 100000000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        EN,
  input  logic        RE,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [4:0]  ADDR,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        RACK,
  output logic        WACK,
  output logic [15:0] LED,
  output logic [15:0] GPIO,
  output logic [7:0]  IRQ
);

  localparam logic [7:0]  MHZ         = 8'(BOARD_CK / 1000000);
  localparam logic [7:0]  KHZ         = 8'((BOARD_CK / 10000) % 100);
  localparam logic [31:0] RELOAD_INIT = 32'(BOARD_CK / 1000000 - 1);
  localparam logic [3:0]  WS_LAST     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  io_state_t   state, state_n;
  io_req_t     req, req_n;
  logic [3:0]  wcnt, wcnt_n;
  logic [31:0] rdata, datao_n;
  logic [31:0] reload, count;
  logic        wr_fire;
  logic        unused_addr;

  assign unused_addr = ^ADDR[1:0];

  always_comb begin
    state_n = state;
    req_n   = req;
    wcnt_n  = wcnt;
    unique case (state)
      IDLE: if (EN && (RE || WE)) begin
        req_n   = '{wr: WE, idx: ADDR[4:2], be: BE, data: DATAI};
        wcnt_n  = '0;
        state_n = (WAIT_STATES > 0) ? WAIT : ACK;
      end
      WAIT: if (wcnt == WS_LAST) state_n = ACK;
            else wcnt_n = wcnt + 4'd1;
      ACK:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // req_n carries the fresh address in the accept cycle, so zero-wait reads still register in time.
  always_comb begin
    rdata = '0;
    unique case (req_n.idx)
      IO_INFO:    rdata = {IRQ, KHZ, MHZ, BOARD_ID};
      IO_LEDGPIO: rdata = {GPIO, LED};
      IO_RELOAD:  rdata = reload;
      IO_COUNT:   rdata = count;
      default:    rdata = '0;
    endcase
    datao_n = (state_n == ACK && !req_n.wr) ? rdata : '0;
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state <= IDLE;
      req   <= '0;
      wcnt  <= '0;
      DATAO <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      wcnt  <= wcnt_n;
      DATAO <= datao_n;
    end
  end

  assign RACK    = (state == ACK) && !req.wr;
  assign WACK    = (state == ACK) &&  req.wr;
  assign wr_fire = WACK;

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      LED  <= '0;
      GPIO <= '0;
    end else if (wr_fire && req.idx == IO_LEDGPIO) begin
      if (req.be[0]) LED[7:0]   <= req.data[7:0];
      if (req.be[1]) LED[15:8]  <= req.data[15:8];
      if (req.be[2]) GPIO[7:0]  <= req.data[23:16];
      if (req.be[3]) GPIO[15:8] <= req.data[31:24];
    end
  end

  dark_io_timer #(.RELOAD_INIT(RELOAD_INIT)) u_timer (
    .clk       (XCLK),
    .rst       (XRES),
    .reload_we (wr_fire && req.idx == IO_RELOAD),
    .be        (req.be),
    .wdata     (req.data),
    .ack_we    (wr_fire && req.idx == IO_INFO && req.be[3]),
    .ack_mask  (req.data[31:24]),
    .reload    (reload),
    .count     (count),
    .irq       (IRQ)
  );

endmodule

// File: tb/tb_dark_io_responder.sv
// Directed bench: a zero-wait instance and a three-wait instance driven with hand-computed vectors.
module tb_dark_io_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res[2], en[2], re[2], we[2];
  logic [3:0]  be[2];
  logic [4:0]  addr[2];
  logic [31:0] datai[2], datao[2];
  logic        rack[2], wack[2];
  logic [15:0] led[2], gpio[2];
  logic [7:0]  irq[2];

  dark_io_responder #(.BOARD_ID(8'h05), .BOARD_CK(100000000), .WAIT_STATES(0)) u0 (
    .XCLK(clk), .XRES(res[0]), .EN(en[0]), .RE(re[0]), .WE(we[0]), .BE(be[0]),
    .ADDR(addr[0]), .DATAI(datai[0]), .DATAO(datao[0]), .RACK(rack[0]), .WACK(wack[0]),
    .LED(led[0]), .GPIO(gpio[0]), .IRQ(irq[0]));

  dark_io_responder #(.BOARD_ID(8'h05), .BOARD_CK(100000000), .WAIT_STATES(3)) u1 (
    .XCLK(clk), .XRES(res[1]), .EN(en[1]), .RE(re[1]), .WE(we[1]), .BE(be[1]),
    .ADDR(addr[1]), .DATAI(datai[1]), .DATAO(datao[1]), .RACK(rack[1]), .WACK(wack[1]),
    .LED(led[1]), .GPIO(gpio[1]), .IRQ(irq[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus access; lat counts cycles from accept edge to the ack cycle (-1 on timeout).
  task automatic access(input int d, input logic w, input logic r, input logic [4:0] a,
                        input logic [3:0] b, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic got_r, output logic got_w, output logic extra);
    @(negedge clk);
    en[d] = 1'b1; we[d] = w; re[d] = r; addr[d] = a; be[d] = b; datai[d] = wd;
    @(posedge clk);
    @(negedge clk);
    en[d] = 1'b0; we[d] = 1'b0; re[d] = 1'b0;
    lat = -1; rd = '0; got_r = 1'b0; got_w = 1'b0; extra = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (rack[d] || wack[d]) begin
        lat = c; rd = datao[d]; got_r = rack[d]; got_w = wack[d];
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      extra = rack[d] | wack[d];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, t;
    logic [31:0] rd;
    logic gr, gw, ex, seen;

    for (int d = 0; d < 2; d++) begin
      res[d] = 1'b1; en[d] = 1'b0; re[d] = 1'b0; we[d] = 1'b0;
      be[d] = '0; addr[d] = '0; datai[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rack", rack[0], 1'b0);
    chk("rst wack", wack[0], 1'b0);
    chk("rst datao", datao[0], 32'h0);
    chk("rst led", led[0], 16'h0);
    chk("rst gpio", gpio[0], 16'h0);
    chk("rst irq", irq[0], 8'h0);
    res[0] = 1'b0; res[1] = 1'b0;

    // COUNT starts at 0, so the first cycle out of reset wraps and raises bit 7.
    repeat (3) @(negedge clk);
    chk("irq first wrap", irq[0], 8'h80);
    access(0, 1'b1, 1'b0, 5'h00, 4'b1000, 32'h8000_0000, lat, rd, gr, gw, ex);
    chk("ack wack", gw, 1'b1);
    chk("ack no rack", gr, 1'b0);
    chk("ack irq cleared", irq[0], 8'h00);

    // Test 1: board info read
    access(0, 1'b0, 1'b1, 5'h00, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("info lat", lat, 1);
    chk("info rack", gr, 1'b1);
    chk("info data", rd, 32'h0000_6405);
    chk("info rack width", ex, 1'b0);

    access(0, 1'b0, 1'b1, 5'h0C, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("reload reset val", rd, 32'd99);

    // Test 2: byte-masked LED/GPIO write
    access(0, 1'b1, 1'b0, 5'h08, 4'b0101, 32'hAABB_CCDD, lat, rd, gr, gw, ex);
    chk("ledgpio wack", gw, 1'b1);
    chk("ledgpio lat", lat, 1);
    chk("led val", led[0], 16'h00DD);
    chk("gpio val", gpio[0], 16'h00BB);
    access(0, 1'b0, 1'b1, 5'h08, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("ledgpio readback", rd, 32'h00BB_00DD);

    // Test 5: unmapped read, RE&&WE treated as write, unmapped write dropped
    access(0, 1'b0, 1'b1, 5'h14, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("unmapped rack", gr, 1'b1);
    chk("unmapped data", rd, 32'h0);
    access(0, 1'b1, 1'b1, 5'h08, 4'b1111, 32'h1122_3344, lat, rd, gr, gw, ex);
    chk("rewe wack", gw, 1'b1);
    chk("rewe no rack", gr, 1'b0);
    chk("rewe led", led[0], 16'h3344);
    chk("rewe gpio", gpio[0], 16'h1122);
    access(0, 1'b1, 1'b0, 5'h1C, 4'b1111, 32'hFFFF_FFFF, lat, rd, gr, gw, ex);
    chk("unmapped wr wack", gw, 1'b1);
    chk("unmapped wr led", led[0], 16'h3344);

    // Test 4: new reload only applies after the pending wrap of the old period
    access(0, 1'b1, 1'b0, 5'h0C, 4'b1111, 32'd3, lat, rd, gr, gw, ex);
    t = 0;
    while (irq[0] == 8'h0 && t < 200) begin @(negedge clk); t++; end
    chk("irq old period", irq[0], 8'h80);
    access(0, 1'b1, 1'b0, 5'h00, 4'b1000, 32'h8000_0000, lat, rd, gr, gw, ex);
    chk("irq acked", irq[0], 8'h00);
    t = 0;
    while (irq[0] == 8'h0 && t < 6) begin @(negedge clk); t++; end
    chk("irq rewrap", irq[0], 8'h80);
    chk("irq rewrap within 4", (t <= 4), 1'b1);
    access(0, 1'b0, 1'b1, 5'h0C, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("reload readback", rd, 32'd3);

    // RELOAD=0 freezes the timer: no new IRQ after ack
    access(0, 1'b1, 1'b0, 5'h0C, 4'b1111, 32'd0, lat, rd, gr, gw, ex);
    access(0, 1'b1, 1'b0, 5'h00, 4'b1000, 32'h8000_0000, lat, rd, gr, gw, ex);
    repeat (12) @(negedge clk);
    chk("frozen no irq", irq[0], 8'h00);

    // Test 3: three wait states
    access(1, 1'b0, 1'b1, 5'h08, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("ws3 lat", lat, 4);
    chk("ws3 rack", gr, 1'b1);
    chk("ws3 rack width", ex, 1'b0);
    chk("ws3 data", rd, 32'h0);

    // Test 6: reset during WAIT of a reload write aborts it
    @(negedge clk);
    en[1] = 1'b1; we[1] = 1'b1; re[1] = 1'b0; addr[1] = 5'h0C; be[1] = 4'hF; datai[1] = 32'd5;
    @(posedge clk);
    @(negedge clk);
    en[1] = 1'b0; we[1] = 1'b0; res[1] = 1'b1;
    @(negedge clk);
    res[1] = 1'b0;
    seen = wack[1];
    repeat (6) begin @(negedge clk); seen |= wack[1]; end
    chk("abort no wack", seen, 1'b0);
    access(1, 1'b0, 1'b1, 5'h0C, 4'b0000, 32'h0, lat, rd, gr, gw, ex);
    chk("abort idle lat", lat, 4);
    chk("abort reload", rd, 32'd99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
